// File: rtl/calc_sequencer.sv
// calc_sequencer: MiniCalculator operation sequencer (button -> multi-cycle ALU).
// Optional one-deep pending-op slot enabled by defining CALC_SEQ_PENDING_EN.
module calc_sequencer #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         btn_i,
    input  logic [WIDTH-1:0]   opa_i,
    input  logic [WIDTH-1:0]   opb_i,
    output logic               alu_start_o,
    output logic [1:0]         alu_op_o,
    output logic [WIDTH-1:0]   alu_a_o,
    output logic [WIDTH-1:0]   alu_b_o,
    input  logic               alu_done_i,
    input  logic [2*WIDTH-1:0] alu_result_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               result_valid_o,
    output logic               done_o,
    output logic               busy_o,
    output logic               err_divzero_o,
    output logic               err_timeout_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [1:0]  OP_DIV   = 2'b11;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t               state_q;
    logic [1:0]           op_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic                 start_q;
    logic [2*WIDTH-1:0]   result_q;
    logic                 rv_q;
    logic                 done_q;
    logic                 busy_q;
    logic                 divz_q;
    logic                 tmo_q;
    logic [15:0]          cnt_q;

    // Op offered to the FSM this cycle (button or pending slot)
    logic                 acc_vld_d;
    logic [1:0]           acc_op_d;
    logic [WIDTH-1:0]     acc_a_d;
    logic [WIDTH-1:0]     acc_b_d;

    // Highest-priority pressed button wins: add > sub > mul > div
    function automatic logic [1:0] enc_op(input logic [3:0] b);
        logic [1:0] op;
        op = OP_DIV;
        priority case (1'b1)
            b[3]:    op = 2'b00;
            b[2]:    op = 2'b01;
            b[1]:    op = 2'b10;
            default: op = OP_DIV;
        endcase
        return op;
    endfunction

`ifdef CALC_SEQ_PENDING_EN
    logic             pend_q;
    logic [1:0]       pend_op_q;
    logic [WIDTH-1:0] pend_a_q;
    logic [WIDTH-1:0] pend_b_q;

    // A full slot takes precedence over a live press in IDLE
    always_comb begin
        acc_vld_d = 1'b0;
        acc_op_d  = enc_op(btn_i);
        acc_a_d   = opa_i;
        acc_b_d   = opb_i;
        if (pend_q) begin
            acc_vld_d = 1'b1;
            acc_op_d  = pend_op_q;
            acc_a_d   = pend_a_q;
            acc_b_d   = pend_b_q;
        end else begin
            acc_vld_d = (btn_i != 4'b0000);
        end
    end

    // Slot fills on the first press while busy, drains in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q    <= 1'b0;
            pend_op_q <= 2'b00;
            pend_a_q  <= '0;
            pend_b_q  <= '0;
        end else if (state_q == IDLE) begin
            pend_q <= 1'b0;
        end else if (btn_i != 4'b0000 && !pend_q) begin
            pend_q    <= 1'b1;
            pend_op_q <= enc_op(btn_i);
            pend_a_q  <= opa_i;
            pend_b_q  <= opb_i;
        end
    end
`else
    // Only a live press can start an op
    always_comb begin
        acc_vld_d = (btn_i != 4'b0000);
        acc_op_d  = enc_op(btn_i);
        acc_a_d   = opa_i;
        acc_b_d   = opb_i;
    end
`endif

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= 2'b00;
            a_q      <= '0;
            b_q      <= '0;
            start_q  <= 1'b0;
            result_q <= '0;
            rv_q     <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            divz_q   <= 1'b0;
            tmo_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (acc_vld_d) begin
                        op_q     <= acc_op_d;
                        a_q      <= acc_a_d;
                        b_q      <= acc_b_d;
                        result_q <= '0;
                        tmo_q    <= 1'b0;
                        if (acc_op_d == OP_DIV && acc_b_d == '0) begin
                            // Divide-by-zero resolves without the ALU
                            rv_q   <= 1'b1;
                            divz_q <= 1'b1;
                            done_q <= 1'b1;
                        end else begin
                            rv_q    <= 1'b0;
                            divz_q  <= 1'b0;
                            start_q <= 1'b1;
                            busy_q  <= 1'b1;
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (alu_done_i) begin
                        result_q <= alu_result_i;
                        rv_q     <= 1'b1;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end else if (cnt_q == TMO_LAST) begin
                        tmo_q   <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign alu_start_o    = start_q;
    assign alu_op_o       = op_q;
    assign alu_a_o        = a_q;
    assign alu_b_o        = b_q;
    assign result_o       = result_q;
    assign result_valid_o = rv_q;
    assign done_o         = done_q;
    assign busy_o         = busy_q;
    assign err_divzero_o  = divz_q;
    assign err_timeout_o  = tmo_q;

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Operation sequencer for the MiniCalculator datapath. It accepts one-hot, single-cycle operator pulses from the button debouncer, captures the operands, and drives a multi-cycle ALU through a start/done handshake. It then latches the result and status flags for the display logic. It also rejects divide-by-zero without using the ALU and bounds every ALU operation with a timeout.

## Interface
Parameters:
- WIDTH, 8, operand width; results are 2*WIDTH wide.
- TIMEOUT, 64, maximum WAIT cycles before abort; legal range 1..65535.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- btn_i  input  4  debounced operator pulses: [3] add, [2] sub, [1] mul, [0] div.
- opa_i  input  WIDTH  operand A (switches).
- opb_i  input  WIDTH  operand B (switches).
- alu_start_o  output  1  one-cycle start strobe to the ALU.
- alu_op_o  output  2  op code: 00 add, 01 sub, 10 mul, 11 div.
- alu_a_o, alu_b_o  output  WIDTH  registered operands, stable from capture until the next capture.
- alu_done_i  input  1  ALU completion strobe.
- alu_result_i  input  2*WIDTH  ALU result; valid while alu_done_i is high.
- result_o  output  2*WIDTH  latched result.
- result_valid_o  output  1  result_o holds the result of the last accepted op.
- done_o  output  1  one-cycle pulse on every op completion: success, divide-by-zero or timeout.
- busy_o  output  1  high in ISSUE and WAIT.
- err_divzero_o, err_timeout_o  output  1  sticky error flags.

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE, btn_i != 0: the op is accepted.
  - Priority when several bits are set: [3] > [2] > [1] > [0].
  - The op code, opa_i and opb_i are captured.
  - result_valid_o, err_divzero_o and err_timeout_o are cleared.
  - Next state is ISSUE.
- Divide-by-zero: div accepted with opb_i == 0.
  - No ISSUE; the FSM stays in IDLE.
  - At the same edge: result_o <= 0, result_valid_o <= 1, err_divzero_o <= 1, done_o <= 1.
- ISSUE: alu_start_o = 1 for exactly this cycle; next state is WAIT; the timeout counter is cleared.
- WAIT: alu_done_i = 1 completes the op.
  - At that edge: result_o <= alu_result_i, result_valid_o <= 1, done_o <= 1.
  - Next state is IDLE.
- WAIT, no done: the counter increments each cycle.
  - When the counter reaches TIMEOUT-1 without done: err_timeout_o <= 1, done_o <= 1, next state IDLE.
  - result_o and result_valid_o stay 0.
- alu_done_i is ignored in IDLE and ISSUE.
- btn_i is ignored in ISSUE and WAIT; it is dropped unless the pending feature is compiled in.
- Arithmetic is the ALU's job. The sequencer checks only opb_i == 0 for div; it does no other arithmetic.

## Timing
- Reset values (asynchronous):
  - State IDLE.
  - alu_start_o = 0, alu_op_o = 00, alu_a_o = alu_b_o = 0.
  - result_o = 0, result_valid_o = 0, done_o = 0, busy_o = 0.
  - Both error flags 0, counter 0, pending empty.
- Reset asserted mid-operation aborts at once. A late alu_done_i after reset release is ignored (IDLE).
- Op accepted at cycle N:
  - alu_start_o high in N+1; busy_o high from N+1.
  - WAIT begins at N+2.
- alu_done_i high at cycle M (M ≥ N+2): result_o, result_valid_o and done_o update at M+1; busy_o is low at M+1.
- Minimum op-to-op spacing is 3 cycles (IDLE, ISSUE, WAIT).
- Timeout: if WAIT starts at N+2, done_o is asserted at N+2+TIMEOUT.
- Divide-by-zero: flags, result and done_o all change at N+1; busy_o never asserts.
- done_o is a single-cycle pulse. result_valid_o and the error flags hold until the next accepted op.

## Configuration
- CALC_SEQ_PENDING_EN defined:
  - A one-deep pending slot captures the op (by the same priority rule), opa_i and opb_i when btn_i != 0 during ISSUE or WAIT.
  - First press wins; further presses while the slot is full are dropped.
  - In IDLE, a full slot is consumed exactly like a button press. An external btn_i in that same cycle is dropped.
  - This leaves exactly one IDLE cycle in which the previous result is visible. The slot empties on consumption and on reset.
- CALC_SEQ_PENDING_EN undefined: no slot; presses during ISSUE or WAIT are lost.

## Test plan
- Reset, then btn_i=1000 with A=5, B=3; ALU returns 8 two cycles into WAIT.
  - Required: alu_start_o single pulse at N+1, alu_op_o=00, result_o=8, result_valid_o=1, one done_o pulse, no errors.
- btn_i=0001 with B=0.
  - Required: no alu_start_o; at N+1 result_o=0, err_divzero_o=1, done_o=1, busy_o=0.
- TIMEOUT=4, op mul with alu_done_i held low.
  - Required: done_o at N+6, err_timeout_o=1, result_valid_o=0.
  - Next op clears err_timeout_o.
- btn_i=1111 in IDLE.
  - Required: the add op is issued.
  - btn_i=0100 during WAIT without the macro is ignored; exactly one done_o.
- With CALC_SEQ_PENDING_EN: sub pressed, then mul pressed during the sub's WAIT, then div pressed during the same WAIT.
  - Required: mul is issued after a single IDLE cycle and div is dropped; two done_o pulses total.
- rst asserted during WAIT, then alu_done_i pulses after release.
  - Required: all outputs at reset values; the late done is ignored.
